// File: rtl/lcg_gen.sv
// Linear congruential generator: streams num_values outputs x[n+1] = (a*x[n] + c) mod m
// over valid/ready, reducing with a bit-serial restoring remainder (one dividend bit per cycle).
module lcg_gen #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] MODULUS,
  input  logic [WIDTH-1:0] MULTIPLIER,
  input  logic [WIDTH-1:0] INCREMENT,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [CNT_W-1:0] num_values,
  input  logic             seed_valid,
  output logic             seed_ready,
  output logic [WIDTH-1:0] out_value,
  output logic [CNT_W-1:0] out_index,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam int DW = 2*WIDTH + 1;
  localparam int BW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, MUL, REDUCE, OUT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] m_r, a_r, c_r, x_r;
  logic [CNT_W-1:0] n_r;
  logic [DW-1:0]    dividend, full;
  logic [WIDTH:0]   rem, trial, rem_next;
  logic [BW-1:0]    bit_cnt;
  logic             accept, handshake, last_bit, last_val;

  assign seed_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign out_valid  = (state == OUT);
  assign accept     = seed_valid && (state == IDLE);
  assign handshake  = out_ready && (state == OUT);
  assign last_bit   = (bit_cnt == BW'(DW-1));
  assign last_val   = (out_index == n_r - CNT_W'(1));
  assign full       = DW'(a_r) * DW'(x_r) + DW'(c_r);

  // rem < m <= 2^WIDTH-1 always, so the shifted trial fits in WIDTH+1 bits
  always_comb begin
    trial    = (rem << 1) | (WIDTH+1)'(dividend[DW-1]);
    rem_next = trial;
    if (trial >= {1'b0, m_r})
      rem_next = trial - {1'b0, m_r};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && num_values != '0) state_next = MUL;
      MUL:     state_next = (m_r == '0) ? OUT : REDUCE;
      REDUCE:  if (last_bit) state_next = OUT;
      OUT:     if (handshake) state_next = last_val ? IDLE : MUL;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      out_value <= '0;
      out_index <= '0;
      done      <= 1'b0;
      m_r       <= '0;
      a_r       <= '0;
      c_r       <= '0;
      x_r       <= '0;
      n_r       <= '0;
      dividend  <= '0;
      rem       <= '0;
      bit_cnt   <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          m_r       <= MODULUS;
          a_r       <= MULTIPLIER;
          c_r       <= INCREMENT;
          x_r       <= seed_in;
          n_r       <= num_values;
          out_index <= '0;
          done      <= (num_values == '0);
        end
        MUL: begin
          dividend <= full;
          rem      <= '0;
          bit_cnt  <= '0;
          if (m_r == '0)
            out_value <= full[WIDTH-1:0];
        end
        REDUCE: begin
          dividend <= dividend << 1;
          rem      <= rem_next;
          bit_cnt  <= bit_cnt + BW'(1);
          if (last_bit)
            out_value <= rem_next[WIDTH-1:0];
        end
        OUT: if (handshake) begin
          x_r <= out_value;
          if (last_val)
            done <= 1'b1;
          else
            out_index <= out_index + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lcg_gen.md
Name: lcg_gen

Overview:
Pseudo-random source that the seed-guessing logic attacks. It accepts a seed and LCG constants, then streams num_values outputs x[n+1] = (a*x[n] + c) mod m over a valid/ready interface. Reduction is sequential, one quotient bit per cycle, with no hardware divider. It drives the guesser's expected_v* inputs in self-test builds and emits known sequences in simulation.

Parameters:
WIDTH, 32, width of seed, constants and outputs.
CNT_W, 16, width of num_values and out_index.

Ports:
CLK  in  1  system clock (16 MHz on board).
RST  in  1  synchronous, active-high reset.
MODULUS  in  WIDTH  m; 0 means 2^WIDTH (plain truncation). Sampled at seed acceptance.
MULTIPLIER  in  WIDTH  a. Sampled at seed acceptance.
INCREMENT  in  WIDTH  c. Sampled at seed acceptance.
seed_in  in  WIDTH  initial state x0.
num_values  in  CNT_W  number of outputs to produce. Sampled at seed acceptance.
seed_valid  in  1  seed request.
seed_ready  out  1  high only in IDLE.
out_value  out  WIDTH  current LCG output.
out_index  out  CNT_W  0-based index of out_value in the stream.
out_valid  out  1  output handshake valid.
out_ready  in  1  output handshake ready.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse when the stream completes.

Behaviour:
- Reset: on any CLK edge with RST=1, the block goes to IDLE. out_valid, done, busy, out_value and out_index all become 0. Works mid-operation: an in-flight value is dropped and never presented.
- States: IDLE, MUL, REDUCE, OUT.
- IDLE: seed_ready=1. When seed_valid & seed_ready:
  - latch MODULUS, MULTIPLIER, INCREMENT, seed_in and num_values; clear out_index.
  - If num_values==0: stay in IDLE and pulse done in the next cycle. No output is produced.
  - Otherwise go to MUL.
- MUL, one cycle: dividend = a*x + c, computed at full 2*WIDTH+1 bits with no overflow.
  - m!=0: go to REDUCE.
  - m==0: out_value = dividend[WIDTH-1:0]; go to OUT.
- REDUCE, exactly 2*WIDTH+1 cycles of restoring reduction, MSB first:
  - r = {r, next dividend bit}; if r >= m then r = r - m.
  - r is WIDTH+1 bits wide.
  - After the last bit, out_value = r (always < m); go to OUT.
- OUT: out_valid=1.
  - out_value and out_index stay stable until out_valid & out_ready.
  - On handshake, out_valid drops in the next cycle and x takes out_value.
  - If out_index == num_values-1: return to IDLE and pulse done in the same cycle busy falls.
  - Otherwise increment out_index and go to MUL.
- Latency, with acceptance or handshake at edge T:
  - m!=0: out_valid rises after edge T+2*WIDTH+3, i.e. 67 cycles for WIDTH=32.
  - m==0: out_valid rises after edge T+2.
- out_ready held high: one output every 2*WIDTH+3 cycles (m!=0) or every 2 cycles (m==0).
- x0 >= m is legal: reduction is applied to a*x0+c, not to x0.
- Constant inputs may change freely after acceptance with no effect until the next seed.
- seed_valid outside IDLE is ignored. No queuing.
- out_ready without out_valid is ignored.
- num_values = 2^CNT_W-1 must complete without out_index wrapping.
- m=1: every output is 0.
- a=0: every output is c mod m.

Test Plan:
- m=993441, a=4001, c=60211, seed 96, num_values 3, out_ready=1 -> outputs 444307, 466569, 127141 at index 0,1,2. First out_valid 67 cycles after acceptance. done pulses once, after the third handshake.
- Same stream with m=0 -> outputs 444307, 1777732518, 242022553. Each output arrives 2 cycles after the previous handshake.
- Case 1 with out_ready low for 10 cycles on index 1 -> out_value holds 466569 with out_valid=1 throughout. Sequence is unchanged after release.
- num_values=0 -> seed_ready stays 1, done pulses 1 cycle after acceptance, out_valid never asserts.
- RST asserted at cycle 30 of REDUCE -> next cycle IDLE with all outputs 0. A fresh seed 96 then reproduces 444307.
- Edge constants: m=1 -> all outputs 0. m=0xFFFFFFFF, a=0xFFFFFFFF, c=0xFFFFFFFF, seed 0xFFFFFFFE -> out_value 0xFFFFFFFF - 0xFFFFFFFF*... reference model check with the 65-bit dividend and no truncation.
